// File: rtl/dht11_display.sv
// dht11_display
// Shows the DHT11 temperature or humidity integer byte on a multiplexed
// 3-digit, active-low 7-segment display. The shown page flips every
// PAGE_CYCLES clocks. A serial double-dabble converter turns the selected
// byte into BCD. The display registers change only when a conversion
// completes, so a partial result never reaches the segments.
//
// Ports
//   clk1mhz   in   1  system clock, 1 MHz, rising edge
//   rst_n     in   1  asynchronous active-low reset
//   temp      in   8  temperature byte (binary)
//   humidity  in   8  humidity byte (binary)
//   seg_n     out  8  segments, active-low, bit0=a .. bit6=g, bit7=dp
//   dig_en_n  out  3  digit enables, active-low one-hot, bit0=hundreds
//   show_hum  out  1  current page, 0=temperature, 1=humidity
//   busy      out  1  BCD conversion in progress
module dht11_display #(
  parameter int SCAN_DIV    = 1000,
  parameter int PAGE_CYCLES = 2000000
) (
  input  logic       clk1mhz,
  input  logic       rst_n,
  input  logic [7:0] temp,
  input  logic [7:0] humidity,
  output logic [7:0] seg_n,
  output logic [2:0] dig_en_n,
  output logic       show_hum,
  output logic       busy
);

  typedef enum logic [1:0] {IDLE, ADJ, SHIFT, DONE} state_t;

  state_t      state;
  logic [23:0] page_cnt;
  logic [15:0] scan_cnt;
  logic [1:0]  dig_idx;
  logic [19:0] shreg;
  logic [2:0]  iter;
  logic [7:0]  snapshot;
  logic        pending;
  logic [3:0]  disp_h, disp_t, disp_o;

  logic        page_wrap;
  logic [7:0]  sel_val;
  logic        req;
  logic [7:0]  seg_next;
  logic [2:0]  dig_next;

  assign page_wrap = (page_cnt == 24'(PAGE_CYCLES - 1));

  // The wrap cycle already selects the byte of the page that show_hum is
  // about to switch to. Then a page flip converts the new page's value
  // once, even when that value changes on the same edge.
  assign sel_val = (show_hum ^ page_wrap) ? humidity : temp;
  assign req     = page_wrap | (sel_val != snapshot);

  function automatic logic [19:0] bcd_adj(input logic [19:0] s);
    logic [19:0] r;
    r = s;
    if (r[19:16] >= 4'd5) r[19:16] = r[19:16] + 4'd3;
    if (r[15:12] >= 4'd5) r[15:12] = r[15:12] + 4'd3;
    if (r[11:8]  >= 4'd5) r[11:8]  = r[11:8]  + 4'd3;
    return r;
  endfunction

  function automatic logic [7:0] glyph(input logic [3:0] d);
    logic [7:0] g;
    case (d)
      4'd0:    g = 8'hC0;
      4'd1:    g = 8'hF9;
      4'd2:    g = 8'hA4;
      4'd3:    g = 8'hB0;
      4'd4:    g = 8'h99;
      4'd5:    g = 8'h92;
      4'd6:    g = 8'h82;
      4'd7:    g = 8'hF8;
      4'd8:    g = 8'h80;
      4'd9:    g = 8'h90;
      default: g = 8'hFF;
    endcase
    return g;
  endfunction

  always_ff @(posedge clk1mhz or negedge rst_n) begin
    if (!rst_n) begin
      page_cnt <= '0;
      show_hum <= 1'b0;
    end else if (page_wrap) begin
      page_cnt <= '0;
      show_hum <= ~show_hum;
    end else begin
      page_cnt <= page_cnt + 24'd1;
    end
  end

  // pending resets to 1 so the first edge after reset starts a conversion.
  // While busy, any request folds into the single pending flag.
  always_ff @(posedge clk1mhz or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      busy     <= 1'b0;
      shreg    <= '0;
      iter     <= '0;
      snapshot <= '0;
      pending  <= 1'b1;
      disp_h   <= '0;
      disp_t   <= '0;
      disp_o   <= '0;
    end else begin
      if (state != IDLE && req) pending <= 1'b1;
      case (state)
        IDLE: begin
          if (req || pending) begin
            shreg    <= {12'b0, sel_val};
            snapshot <= sel_val;
            pending  <= 1'b0;
            iter     <= '0;
            busy     <= 1'b1;
            state    <= ADJ;
          end
        end
        ADJ: begin
          shreg <= bcd_adj(shreg);
          state <= SHIFT;
        end
        SHIFT: begin
          shreg <= {shreg[18:0], 1'b0};
          iter  <= iter + 3'd1;
          state <= (iter == 3'd7) ? DONE : ADJ;
        end
        DONE: begin
          disp_h <= shreg[19:16];
          disp_t <= shreg[15:12];
          disp_o <= shreg[11:8];
          busy   <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Leading-zero blanking. The ones digit is always lit, and its dp marks
  // the humidity page.
  always_comb begin
    seg_next = 8'hFF;
    dig_next = 3'b111;
    case (dig_idx)
      2'd0: begin
        dig_next = 3'b110;
        seg_next = (disp_h == 4'd0) ? 8'hFF : glyph(disp_h);
      end
      2'd1: begin
        dig_next = 3'b101;
        seg_next = (disp_h == 4'd0 && disp_t == 4'd0) ? 8'hFF : glyph(disp_t);
      end
      2'd2: begin
        dig_next = 3'b011;
        seg_next = glyph(disp_o) & {~show_hum, 7'h7F};
      end
      default: begin
        seg_next = 8'hFF;
        dig_next = 3'b111;
      end
    endcase
  end

  always_ff @(posedge clk1mhz or negedge rst_n) begin
    if (!rst_n) begin
      scan_cnt <= '0;
      dig_idx  <= '0;
      seg_n    <= 8'hFF;
      dig_en_n <= 3'b111;
    end else begin
      if (scan_cnt == 16'(SCAN_DIV - 1)) begin
        scan_cnt <= '0;
        dig_idx  <= (dig_idx == 2'd2) ? 2'd0 : dig_idx + 2'd1;
      end else begin
        scan_cnt <= scan_cnt + 16'd1;
      end
      seg_n    <= seg_next;
      dig_en_n <= dig_next;
    end
  end

endmodule

// File: tb/tb_dht11_display.sv
// tb_dht11_display
// Directed bench for dht11_display with SCAN_DIV=4 and PAGE_CYCLES=200.
// Each time stimulus will cause a conversion, the bench queues the expected
// three glyphs and the expected page. One monitor measures every busy pulse.
// A second monitor waits for each completed conversion, records a full
// scan, and compares it with the head of the queue.
module tb_dht11_display;

  localparam int SCAN_DIV    = 4;
  localparam int PAGE_CYCLES = 200;

  typedef struct packed {
    logic [7:0] h;
    logic [7:0] t;
    logic [7:0] o;
    logic       hum;
  } exp_t;

  logic       clk1mhz = 1'b0;
  logic       rst_n   = 1'b0;
  logic [7:0] temp    = 8'd0;
  logic [7:0] humidity = 8'd0;
  logic [7:0] seg_n;
  logic [2:0] dig_en_n;
  logic       show_hum;
  logic       busy;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   cyc;
  int   done_cnt = 0;

  always #5 clk1mhz = ~clk1mhz;

  dht11_display #(.SCAN_DIV(SCAN_DIV), .PAGE_CYCLES(PAGE_CYCLES)) dut (
    .clk1mhz (clk1mhz),
    .rst_n   (rst_n),
    .temp    (temp),
    .humidity(humidity),
    .seg_n   (seg_n),
    .dig_en_n(dig_en_n),
    .show_hum(show_hum),
    .busy    (busy)
  );

  // Clock edges since the most recent reset release.
  always @(posedge clk1mhz or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic expect_disp(input logic [7:0] h, input logic [7:0] t, input logic [7:0] o, input logic hum);
    exp_t e;
    e.h = h; e.t = t; e.o = o; e.hum = hum;
    sb_q.push_back(e);
  endtask

  task automatic wait_until(input int n);
    while (cyc < n) @(negedge clk1mhz);
  endtask

  task automatic apply_stimulus(input int at_cyc, input logic [7:0] t, input logic [7:0] h);
    wait_until(at_cyc);
    temp     = t;
    humidity = h;
  endtask

  // Every busy pulse must last exactly 17 cycles. A pulse that reset cuts
  // short is discarded.
  initial begin : busy_mon
    int   run;
    logic prev;
    run  = 0;
    prev = 1'b0;
    forever begin
      @(negedge clk1mhz);
      if (!rst_n) begin
        run  = 0;
        prev = 1'b0;
      end else begin
        if (busy) run++;
        else if (prev) begin
          check_output("busy_len", 32'(run), 32'd17);
          run = 0;
          done_cnt++;
        end
        prev = busy;
      end
    end
  end

  // After each completed conversion, record one full scan and compare it
  // with the oldest expected entry.
  initial begin : sb_mon
    int         handled;
    logic [7:0] got [3];
    exp_t       a;
    exp_t       e;
    handled = 0;
    forever begin
      wait (done_cnt > handled);
      handled++;
      got[0] = 8'bx; got[1] = 8'bx; got[2] = 8'bx;
      repeat (3 * SCAN_DIV) begin
        @(negedge clk1mhz);
        case (dig_en_n)
          3'b110:  got[0] = seg_n;
          3'b101:  got[1] = seg_n;
          3'b011:  got[2] = seg_n;
          default: ;
        endcase
      end
      a.h = got[0]; a.t = got[1]; a.o = got[2]; a.hum = show_hum;
      if (sb_q.size() == 0) begin
        n_checks++;
        $display("[TB] FAIL unexpected_conversion: got %h, expected none", a);
      end else begin
        e = sb_q.pop_front();
        check_output("display", 32'(a), 32'(e));
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stim
    logic [2:0] pats [3];
    logic [2:0] prev;
    logic       found;
    int         n;
    pats[0] = 3'b110; pats[1] = 3'b101; pats[2] = 3'b011;

    // Reset values.
    rst_n = 1'b0; temp = 8'd25; humidity = 8'd7;
    repeat (3) @(negedge clk1mhz);
    check_output("rst_seg",  seg_n,    8'hFF);
    check_output("rst_dig",  dig_en_n, 3'b111);
    check_output("rst_busy", busy,     1'b0);
    check_output("rst_hum",  show_hum, 1'b0);

    // Release reset. The first edge starts the pending conversion of 25.
    expect_disp(8'hFF, 8'hA4, 8'h92, 1'b0);
    rst_n = 1'b1;
    @(negedge clk1mhz);
    check_output("first_dig",  dig_en_n, 3'b110);
    check_output("first_seg",  seg_n,    8'hFF);
    check_output("first_busy", busy,     1'b1);

    // The wrap at edge 200 switches to humidity 7, with dp lit.
    wait_until(100);
    expect_disp(8'hFF, 8'hFF, 8'h78, 1'b1);

    // Temperature 255 shows after the wrap at edge 400.
    expect_disp(8'hA4, 8'h92, 8'h92, 1'b0);
    apply_stimulus(300, 8'd255, 8'd7);

    // Temperature 100 keeps the inner zero.
    expect_disp(8'hF9, 8'hC0, 8'hC0, 1'b0);
    apply_stimulus(450, 8'd100, 8'd7);

    // Changing the value mid-conversion yields one extra conversion.
    expect_disp(8'hFF, 8'hA4, 8'h92, 1'b0);
    expect_disp(8'hFF, 8'hB0, 8'hF9, 1'b0);
    apply_stimulus(500, 8'd25, 8'd7);
    repeat (3) @(negedge clk1mhz);
    temp = 8'd31;

    // Humidity page again at edge 600.
    wait_until(560);
    expect_disp(8'hFF, 8'hFF, 8'h78, 1'b1);

    // A temperature change lands on the wrap edge at 800. This must give one conversion.
    expect_disp(8'hFF, 8'h99, 8'hA4, 1'b0);
    apply_stimulus(799, 8'd42, 8'd7);

    // Digit scan order and dwell.
    wait_until(840);
    prev  = dig_en_n;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk1mhz);
      if (dig_en_n == 3'b110 && prev != 3'b110) found = 1'b1;
      prev = dig_en_n;
    end
    check_output("scan_sync", found, 1'b1);
    for (int d = 0; d < 3; d++) begin
      check_output($sformatf("scan_pat%0d", d), dig_en_n, pats[d]);
      n = 0;
      while (dig_en_n === pats[d] && n < 20) begin
        n++;
        @(negedge clk1mhz);
      end
      check_output($sformatf("scan_len%0d", d), 32'(n), 32'd4);
    end
    check_output("scan_wrap", dig_en_n, 3'b110);

    // Reset in the middle of a conversion: outputs clear before any clock edge.
    apply_stimulus(870, 8'd99, 8'd7);
    repeat (5) @(negedge clk1mhz);
    #2 rst_n = 1'b0;
    #1;
    check_output("async_seg",  seg_n,    8'hFF);
    check_output("async_dig",  dig_en_n, 3'b111);
    check_output("async_busy", busy,     1'b0);
    check_output("async_hum",  show_hum, 1'b0);
    expect_disp(8'hFF, 8'h90, 8'h90, 1'b0);
    @(negedge clk1mhz);
    @(negedge clk1mhz);
    rst_n = 1'b1;
    repeat (60) @(negedge clk1mhz);
    check_output("queue_empty", 32'(sb_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
